scanline_reader: RTL and testbench

Drains one 160-pixel Game Boy background line from a pair of 20-byte scanline RAMs, one for the low bit-plane and one for the high bit-plane, and emits the pixels as a valid/ready stream. It sits between the tile fetcher that fills the scanline RAMs and the LCD/VGA line sink. The fetcher writes the line; this block reads it back, one 2-bit pixel per accepted transfer, MSB (leftmost) first.

---
 rtl/scanline_reader_if.sv | 11 +
 rtl/scanline_reader.sv | 124 ++++++++++++
 tb/tb_scanline_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scanline_reader_if.sv
// Pixel stream from scanline_reader to the line sink: 2-bit pixel plus
// column, valid/ready handshake.
interface scanline_reader_if;
  logic [1:0] px_data;
  logic [7:0] px_x;
  logic       px_valid;
  logic       px_ready;

  modport master (output px_data, px_x, px_valid, input px_ready);
  modport slave  (input px_data, px_x, px_valid, output px_ready);
endinterface

// File: rtl/scanline_reader.sv
// Reads one 160-pixel background line from the lo/hi plane scanline RAMs and
// streams it out MSB first. Optional palette: `define SCANLINE_READER_PALETTE_EN.
module scanline_reader #(
  parameter int LINE_BYTES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] addr,
  input  logic [7:0] rd_data_lo,
  input  logic [7:0] rd_data_hi,
  input  logic [7:0] bgp,
  scanline_reader_if.master px,
  output logic       busy,
  output logic       line_done
);

  localparam logic [4:0] LAST = 5'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e     state_q, state_d;
  logic [4:0] byte_idx_q, byte_idx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_lo_q, sh_lo_d;
  logic [7:0] sh_hi_q, sh_hi_d;
  logic [7:0] px_x_q, px_x_d;
  logic       xfer;
  logic [1:0] raw_idx;

  assign xfer = (state_q == SHIFT) && px.px_ready;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    sh_lo_d    = sh_lo_q;
    sh_hi_d    = sh_hi_q;
    px_x_d     = px_x_q;
    case (state_q)
      IDLE: if (start && !abort) state_d = LOAD;
      LOAD: begin
        sh_lo_d   = rd_data_lo;
        sh_hi_d   = rd_data_hi;
        bit_cnt_d = 3'd0;
        state_d   = SHIFT;
      end
      SHIFT: if (xfer) begin
        sh_lo_d   = {sh_lo_q[6:0], 1'b0};
        sh_hi_d   = {sh_hi_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        px_x_d    = px_x_q + 8'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_idx_q == LAST) begin
            // Hold column at 159; it is cleared in DONE.
            px_x_d  = px_x_q;
            state_d = DONE;
          end else begin
            // addr already presents byte_idx+1, so reload without a bubble.
            byte_idx_d = byte_idx_q + 5'd1;
            sh_lo_d    = rd_data_lo;
            sh_hi_d    = rd_data_hi;
          end
        end
      end
      DONE: begin
        byte_idx_d = 5'd0;
        bit_cnt_d  = 3'd0;
        px_x_d     = 8'd0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      byte_idx_d = 5'd0;
      bit_cnt_d  = 3'd0;
      px_x_d     = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= 5'd0;
      bit_cnt_q  <= 3'd0;
      sh_lo_q    <= 8'd0;
      sh_hi_q    <= 8'd0;
      px_x_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_lo_q    <= sh_lo_d;
      sh_hi_q    <= sh_hi_d;
      px_x_q     <= px_x_d;
    end
  end

  always_comb begin
    addr = 5'd0;
    case (state_q)
      LOAD:    addr = byte_idx_q;
      SHIFT:   addr = (byte_idx_q == LAST) ? LAST : byte_idx_q + 5'd1;
      default: addr = 5'd0;
    endcase
  end

  assign raw_idx     = {sh_hi_q[7], sh_lo_q[7]};
  assign px.px_valid = (state_q == SHIFT);
  assign px.px_x     = px_x_q;
  assign busy        = (state_q != IDLE);
  assign line_done   = (state_q == DONE);

`ifdef SCANLINE_READER_PALETTE_EN
  assign px.px_data = px.px_valid ? bgp[{raw_idx, 1'b0} +: 2] : 2'd0;
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign px.px_data = px.px_valid ? raw_idx : 2'd0;
`endif

endmodule

// File: tb/tb_scanline_reader.sv
// Directed + randomized bench for scanline_reader; expected pixels come from
// the plane bytes via plain bit arithmetic.
module tb_scanline_reader;
  localparam int LB = 20;
  localparam int NPX = LB * 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] addr;
  logic [7:0] rd_data_lo, rd_data_hi;
  logic [7:0] bgp = 8'hE4;
  logic       busy, line_done;

  logic [7:0] lo_mem [LB];
  logic [7:0] hi_mem [LB];
  logic [1:0] obs_px [NPX];

  int n_chk = 0;
  int n_pass = 0;

  scanline_reader_if px_if ();

  scanline_reader #(.LINE_BYTES(LB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .addr       (addr),
    .rd_data_lo (rd_data_lo),
    .rd_data_hi (rd_data_hi),
    .bgp        (bgp),
    .px         (px_if),
    .busy       (busy),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  assign rd_data_lo = (addr < 5'(LB)) ? lo_mem[addr] : 8'h00;
  assign rd_data_hi = (addr < 5'(LB)) ? hi_mem[addr] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Pixel x: byte x/8, bit 7-x%8 of each plane; hi plane is the index MSB.
  function automatic logic [1:0] exp_px(input int x);
    logic [1:0] idx;
    int b, s;
    b = x / 8;
    s = 7 - (x % 8);
    idx = {hi_mem[b][s], lo_mem[b][s]};
`ifdef SCANLINE_READER_PALETTE_EN
    return bgp[2*idx +: 2];
`else
    return idx;
`endif
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < LB; i++) begin
      case (mode)
        0: begin lo_mem[i] = 8'hFF; hi_mem[i] = 8'h00; end
        1: begin lo_mem[i] = (i == 0) ? 8'h80 : 8'h00; hi_mem[i] = (i == 0) ? 8'h01 : 8'h00; end
        2: begin lo_mem[i] = 8'($urandom); hi_mem[i] = 8'($urandom); end
        default: begin lo_mem[i] = 8'h55; hi_mem[i] = 8'h33; end
      endcase
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_data"}, px_if.px_data, 0);
    chk({tag, "_x"}, px_if.px_x, 0);
    chk({tag, "_valid"}, px_if.px_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, line_done, 0);
  endtask

  // Drives one line. pct: ready probability; stall_at: hold ready low twice
  // on that pixel; abort_at/rst_at: cut the line at that pixel (-1 = never).
  task automatic run_line(input int pct, input int stall_at, input int abort_at,
                          input int rst_at, input bit timed);
    int n, cyc, first, stalls;
    bit fin, rdy;
    n = 0; cyc = 1; first = -1; stalls = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    px_if.px_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_valid", px_if.px_valid, 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk("timeout_px_count", n, NPX);
        fin = 1;
      end else if (line_done) begin
        start = 1'b0;
        chk("done_count", n, NPX);
        chk("done_valid", px_if.px_valid, 0);
        if (timed) begin
          chk("first_px_cycle", first, 2);
          chk("done_cycle", cyc, 162);
        end
        fin = 1;
      end else if (px_if.px_valid) begin
        if (first < 0) first = cyc;
        if (n >= NPX) begin
          chk("overrun_px_count", n, NPX - 1);
          fin = 1;
        end else begin
          chk("px_x", px_if.px_x, n);
          chk("px_data", px_if.px_data, exp_px(n));
          chk("busy_shift", busy, 1);
          obs_px[n] = px_if.px_data;
          if (n == rst_at) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk_reset_outs("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            fin = 1;
          end else if (n == abort_at) begin
            abort = 1'b1;
            start = 1'b0;
            px_if.px_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", px_if.px_valid, 0);
            chk("abort_done", line_done, 0);
            chk("abort_x", px_if.px_x, 0);
            @(negedge clk);
            chk("abort_done2", line_done, 0);
            fin = 1;
          end else begin
            if (n == stall_at && stalls < 2) begin
              rdy = 1'b0;
              stalls++;
            end else begin
              rdy = ($urandom_range(99) < pct);
            end
            px_if.px_ready = rdy;
            // start while busy must be ignored
            start = 1'($urandom_range(1));
            if (rdy) n++;
          end
        end
      end else begin
        px_if.px_ready = 1'($urandom_range(1));
      end
    end
    px_if.px_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_valid", px_if.px_valid, 0);
  endtask

  initial begin
    px_if.px_ready = 1'b0;
    fill(0);
    #2;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_reset");

    // Full line, ready held high, exact cycle timing.
    fill(0);
    run_line(100, -1, -1, -1, 1'b1);
    chk("full_px0", obs_px[0], 2'd1);
    chk("full_px159", obs_px[159], 2'd1);

    // Bit order and byte boundary with no gap.
    fill(1);
    run_line(100, -1, -1, -1, 1'b1);
    chk("bo_px0", obs_px[0], 2'd1);
    chk("bo_px1", obs_px[1], 2'd0);
    chk("bo_px6", obs_px[6], 2'd0);
    chk("bo_px7", obs_px[7], 2'd2);
    chk("bo_px8", obs_px[8], 2'd0);

    // Stall twice on pixel 7 across the byte boundary.
    fill(2);
    run_line(100, 7, -1, -1, 1'b0);

    // Random backpressure, random data.
    for (int k = 0; k < 2; k++) begin
      fill(2);
      run_line(60, -1, -1, -1, 1'b0);
    end

    // Abort at px 50, then a clean restart from column 0.
    fill(2);
    run_line(100, -1, 50, -1, 1'b0);
    run_line(80, -1, -1, -1, 1'b0);

    // Reset mid-line at px 100, then a full line.
    fill(2);
    run_line(100, -1, -1, 100, 1'b0);
    run_line(100, -1, -1, -1, 1'b1);

    // start and abort together in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    @(negedge clk);
    chk("start_abort_busy2", busy, 0);
    chk("start_abort_valid", px_if.px_valid, 0);

`ifdef SCANLINE_READER_PALETTE_EN
    fill(3);
    bgp = 8'hE4;
    run_line(100, -1, -1, -1, 1'b0);
    chk("pal_e4_0", obs_px[0], 2'd0);
    chk("pal_e4_1", obs_px[1], 2'd1);
    chk("pal_e4_2", obs_px[2], 2'd2);
    chk("pal_e4_3", obs_px[3], 2'd3);
    bgp = 8'h1B;
    run_line(100, -1, -1, -1, 1'b0);
    chk("pal_1b_0", obs_px[0], 2'd3);
    chk("pal_1b_1", obs_px[1], 2'd2);
    chk("pal_1b_2", obs_px[2], 2'd1);
    chk("pal_1b_3", obs_px[3], 2'd0);
    bgp = 8'hE4;
`else
    fill(3);
    run_line(100, -1, -1, -1, 1'b0);
    chk("raw_0", obs_px[0], 2'd0);
    chk("raw_1", obs_px[1], 2'd1);
    chk("raw_2", obs_px[2], 2'd2);
    chk("raw_3", obs_px[3], 2'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
